// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   - FSM state encoding (IDLE / RUN / FIX)
//   - operation type (multiply / divide)
//   - move-from codes (MFHI / MFLO)
//   - default iteration count
//   - two's-complement conditional-negate helper
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_e;

    localparam logic [1:0] MF_HI = 2'b10;
    localparam logic [1:0] MF_LO = 2'b11;

    localparam int MD_STEPS_DEFAULT = 32;

    // Returns -v when neg is set, v otherwise (modulo 2^32).
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   Combinational single iteration of an unsigned (magnitude) multiply or
//   divide. The 64-bit working register is split into acc_hi/acc_lo.
//
//   Multiply (shift-add): acc_lo holds the remaining multiplier bits, acc_hi
//   the partial product. If acc_lo[0] is set, opnd is added to acc_hi, then
//   the 65-bit {carry, acc_hi, acc_lo} is shifted right by one.
//
//   Divide (restoring): acc_hi holds the partial remainder, acc_lo the
//   dividend bits still to be consumed / quotient bits produced. {acc_hi,
//   acc_lo} is shifted left by one, opnd is trial-subtracted from the upper
//   part, and the quotient bit shifted in records whether it fit.
//
// Ports
//   op_i      operation select (OP_MUL / OP_DIV)
//   acc_hi_i  upper half of working register
//   acc_lo_i  lower half of working register
//   opnd_i    multiplicand magnitude / divisor magnitude
//   acc_hi_o  next upper half
//   acc_lo_o  next lower half
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_ctrl_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] acc_hi_i,
    input  logic [31:0] acc_lo_i,
    input  logic [31:0] opnd_i,
    output logic [31:0] acc_hi_o,
    output logic [31:0] acc_lo_o
);

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : 33'd0);
    assign div_shift = {acc_hi_i, acc_lo_i[31]};
    // One extra bit so the MSB is a clean borrow flag.
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_i};

    // NOTE: combinational outputs get a default at the top of the block so no
    // path through the if/case can leave them unassigned and infer a latch.
    always_comb begin
        acc_hi_o = acc_hi_i;
        acc_lo_o = acc_lo_i;
        if (op_i == OP_MUL) begin
            acc_hi_o = mul_sum[32:1];
            acc_lo_o = {mul_sum[0], acc_lo_i[31:1]};
        end else if (!div_diff[33]) begin
            // Remainder stays below the divisor, so the difference fits 32 bits.
            // With a zero divisor this path always runs: acc_hi ends up holding
            // the dividend and acc_lo all ones, which is the required result.
            acc_hi_o = div_diff[31:0];
            acc_lo_o = {acc_lo_i[30:0], 1'b1};
        end else begin
            acc_hi_o = div_shift[31:0];
            acc_lo_o = {acc_lo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Iterative signed MULT/DIV unit with HI/LO registers for the EX stage.
//   An operation takes MD_STEPS RUN cycles plus one FIX cycle; the pipeline is
//   held via stall while a new mult/div or a move-from is requested during it.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   mult     MULT request (wins over div)
//   div      DIV request
//   mf       move-from request: 2'b10 MFHI, 2'b11 MFLO, 2'b0x none
//   rs_val   multiplicand / dividend
//   rt_val   multiplier / divisor
//   stall    combinational hold request to the hazard unit
//   busy     registered, high while an operation is in flight
//   hi, lo   registered HI / LO
//   mf_data  combinational move-from data
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MD_STEPS = MD_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mult,
    input  logic        div,
    input  logic [1:0]  mf,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam int              CNT_W    = $clog2(MD_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_STEPS - 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      opnd_q, opnd_d;
    logic [31:0]      acc_hi_q, acc_hi_d;
    logic [31:0]      acc_lo_q, acc_lo_d;
    logic             neg_res_q, neg_res_d;   // product / quotient negative
    logic             neg_rem_q, neg_rem_d;   // remainder negative
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic        sign_xor;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod_mag;
    logic [63:0] prod_signed;

    assign rs_abs   = neg_if(rs_val[31], rs_val);
    assign rt_abs   = neg_if(rt_val[31], rt_val);
    assign sign_xor = rs_val[31] ^ rt_val[31];

    assign prod_mag    = {acc_hi_q, acc_lo_q};
    assign prod_signed = neg_res_q ? (~prod_mag + 64'd1) : prod_mag;

    muldiv_step u_step (
        .op_i     (op_q),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .acc_hi_o (step_hi),
        .acc_lo_o (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (mult) begin
                    state_d   = RUN;
                    op_d      = OP_MUL;
                    cnt_d     = '0;
                    opnd_d    = rs_abs;
                    acc_hi_d  = '0;
                    acc_lo_d  = rt_abs;
                    neg_res_d = sign_xor;
                    neg_rem_d = 1'b0;
                end else if (div) begin
                    state_d   = RUN;
                    op_d      = OP_DIV;
                    cnt_d     = '0;
                    opnd_d    = rt_abs;
                    acc_hi_d  = '0;
                    acc_lo_d  = rs_abs;
                    // Divide by zero keeps LO at all ones: no quotient sign fix.
                    neg_res_d = sign_xor && (rt_val != 32'd0);
                    neg_rem_d = rs_val[31];
                end
            end

            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                state_d = IDLE;
                if (op_q == OP_MUL) begin
                    hi_d = prod_signed[63:32];
                    lo_d = prod_signed[31:0];
                end else begin
                    hi_d = neg_if(neg_rem_q, acc_hi_q);
                    lo_d = neg_if(neg_res_q, acc_lo_q);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    // busy_q is cleared by reset, which also keeps stall low during reset.
    assign stall = busy_q && (mult || div || mf[1]);
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        mf_data = '0;
        case (mf)
            MF_HI:   mf_data = hi_q;
            MF_LO:   mf_data = lo_q;
            default: mf_data = '0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl: a table of mult/div vectors with
//   hand-computed HI/LO and latency, plus sequences for move-from stalling,
//   back-to-back requests and reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int BUSY_CYC = 33;
    localparam int LIMIT    = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mult;
    logic        div;
    logic [1:0]  mf;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl #(.MD_STEPS(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mult    (mult),
        .div     (div),
        .mf      (mf),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .stall   (stall),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mf_data (mf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mult   = is_mult;
        div    = !is_mult;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        mult   = 1'b0;
        div    = 1'b0;
    endtask

    // Counts negedges with busy high; bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < LIMIT) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{"mul 7*-3",       1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"mul 6*5",        1'b1, 32'd6,         32'd5,         32'h0000_0000, 32'd30};
        vecs[2]  = '{"mul -1*-1",      1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'd1};
        vecs[3]  = '{"mul min*min",    1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4]  = '{"mul max*min",    1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[5]  = '{"div 100/7",      1'b0, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6]  = '{"div -7/2",       1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{"div -100/7",     1'b0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};
        vecs[8]  = '{"div 7/-2",       1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{"div 5/0",        1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[10] = '{"div -5/0",       1'b0, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[11] = '{"div min/-1",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[12] = '{"div 3/10",       1'b0, 32'd3,         32'd10,        32'd3,         32'd0};

        rst_n  = 1'b0;
        mult   = 1'b0;
        div    = 1'b0;
        mf     = 2'b00;
        rs_val = '0;
        rt_val = '0;

        // Reset state
        #1;
        check("reset busy", busy, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset stall", stall, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of vectors
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].is_mult, vecs[i].a, vecs[i].b);
            wait_idle(cyc);
            check($sformatf("%s busy cycles", vecs[i].name), cyc, BUSY_CYC);
            check($sformatf("%s hi", vecs[i].name), hi, vecs[i].exp_hi);
            check($sformatf("%s lo", vecs[i].name), lo, vecs[i].exp_lo);
        end

        // MFLO one cycle after mult 6*5; no stall while idle
        @(negedge clk);
        mult   = 1'b1;
        rs_val = 32'd6;
        rt_val = 32'd5;
        #1;
        check("no stall in idle", stall, 0);
        @(negedge clk);
        mult = 1'b0;
        mf   = MF_LO;
        #1;
        check("mflo stall while busy", stall, 1);
        @(negedge clk);
        cyc = 1;
        while (stall === 1'b1 && cyc < LIMIT) begin
            cyc++;
            @(negedge clk);
        end
        check("mflo stalled cycles", cyc, BUSY_CYC);
        check("mflo stall released", stall, 0);
        check("mflo data", mf_data, 32'd30);
        mf = MF_HI;
        #1;
        check("mfhi data", mf_data, 32'd0);
        mf = 2'b01;
        #1;
        check("mf none data", mf_data, 32'd0);
        mf = 2'b00;

        // Back-to-back: div presented while mult is busy
        issue(1'b1, 32'd7, 32'hFFFF_FFFD);
        div    = 1'b1;
        rs_val = 32'd100;
        rt_val = 32'd7;
        #1;
        check("b2b div stalled", stall, 1);
        wait_idle(cyc);
        check("b2b mult busy cycles", cyc, BUSY_CYC);
        check("b2b stall in idle", stall, 0);
        check("b2b mult hi", hi, 32'hFFFF_FFFF);
        check("b2b mult lo", lo, 32'hFFFF_FFEB);
        @(negedge clk);
        div = 1'b0;
        check("b2b div accepted", busy, 1);
        wait_idle(cyc);
        check("b2b div busy cycles", cyc, BUSY_CYC);
        check("b2b div hi", hi, 32'd2);
        check("b2b div lo", lo, 32'd14);

        // Reset at RUN cycle 10 of mult 3*4
        issue(1'b1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        check("pre-reset busy", busy, 1);
        mf    = MF_LO;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort stall", stall, 0);
        check("abort mf_data", mf_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mf    = 2'b00;
        repeat (40) @(negedge clk);
        check("no partial result lo", lo, 0);
        check("no partial result busy", busy, 0);
        issue(1'b1, 32'd2, 32'd2);
        wait_idle(cyc);
        check("post-reset busy cycles", cyc, BUSY_CYC);
        check("post-reset hi", hi, 0);
        check("post-reset lo", lo, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
